// File: rtl/wb_write_arbiter_pkg.sv
// ============================================================================
//  Module   : wb_write_arbiter_pkg
//  Brief    : Shared widths, zero-register constant and queued-result record
//             for the register file writeback arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package wb_write_arbiter_pkg;

   localparam int WB_AW = 5;
   localparam int WB_DW = 32;

   localparam logic [WB_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              valid;
      logic              killed;
      logic [WB_AW-1:0]  addr;
      logic [WB_DW-1:0]  data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_result_fifo.sv
// ============================================================================
//  Module   : wb_result_fifo
//  Brief    : Queue of MDU results awaiting a register file write slot, with
//             per-entry kill-by-address for write-after-write ordering.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_result_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  wb_entry_t              push_entry,
   input  logic                   pop,
   input  logic                   kill_en,
   input  logic [WB_AW-1:0]       kill_addr,
   output wb_entry_t              head,
   output logic [DEPTH-1:0]       live,
   output logic [WB_AW-1:0]       slot_addr [DEPTH],
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] c_ptr_one   = PW'(1);
   localparam logic [PW:0]   c_count_one = (PW+1)'(1);
   localparam logic [PW:0]   c_full      = (PW+1)'(DEPTH);

   wb_entry_t     r_slot [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;

   // Kill is applied first so that a slot refilled this cycle starts clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && r_slot[i].valid && (r_slot[i].addr == kill_addr)) begin
               r_slot[i].killed <= 1'b1;
            end
            if (pop && (r_rd_ptr == PW'(i))) begin
               r_slot[i].valid <= 1'b0;
            end
            if (push && (r_wr_ptr == PW'(i))) begin
               r_slot[i] <= push_entry;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + c_count_one;
            2'b01:   r_count <= r_count - c_count_one;
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_view
         assign live[i]      = r_slot[i].valid && !r_slot[i].killed;
         assign slot_addr[i] = r_slot[i].addr;
      end
   endgenerate

   assign head  = r_slot[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == c_full);

endmodule

`default_nettype wire

// File: rtl/wb_write_arbiter.sv
// ============================================================================
//  Module   : wb_write_arbiter
//  Brief    : Sole register file write port driver; pipeline writeback has
//             absolute priority, queued MDU results fill idle write slots.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pipe_wr,
   input  logic [AW-1:0]          pipe_addr,
   input  logic [DW-1:0]          pipe_data,
   input  logic                   mdu_valid,
   output logic                   mdu_ready,
   input  logic [AW-1:0]          mdu_addr,
   input  logic [DW-1:0]          mdu_data,
   input  logic [AW-1:0]          chk_addr1,
   input  logic [AW-1:0]          chk_addr2,
   output logic                   busy1,
   output logic                   busy2,
   output logic [$clog2(DEPTH):0] mdu_count,
   output logic                   rf_wr,
   output logic [AW-1:0]          rf_addr,
   output logic [DW-1:0]          rf_data
);

   logic             w_pipe_eff;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_head_live;
   wb_entry_t        w_head;
   wb_entry_t        w_push_entry;
   logic [DEPTH-1:0] w_live;
   logic [AW-1:0]    w_slot_addr [DEPTH];
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;

   logic             r_rf_wr;
   logic [AW-1:0]    r_rf_addr;
   logic [DW-1:0]    r_rf_data;

   assign w_pipe_eff = pipe_wr && (pipe_addr != REG_ZERO);
   assign mdu_ready  = !w_full;

   // A result racing a same-cycle pipeline write to its register is already stale.
   assign w_push = mdu_valid && mdu_ready && (mdu_addr != REG_ZERO)
                   && !(w_pipe_eff && (mdu_addr == pipe_addr));

   assign w_push_entry = '{valid: 1'b1, killed: 1'b0, addr: mdu_addr, data: mdu_data};

   assign w_head_live = w_head.valid && !w_head.killed;
   assign w_pop       = w_head.valid && (w_head.killed || !w_pipe_eff);

   wb_result_fifo #(
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_entry (w_push_entry),
      .pop        (w_pop),
      .kill_en    (w_pipe_eff),
      .kill_addr  (pipe_addr),
      .head       (w_head),
      .live       (w_live),
      .slot_addr  (w_slot_addr),
      .count      (mdu_count),
      .full       (w_full)
   );

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_busy
         assign w_hit1[i] = w_live[i] && (w_slot_addr[i] == chk_addr1);
         assign w_hit2[i] = w_live[i] && (w_slot_addr[i] == chk_addr2);
      end
   endgenerate

   assign busy1 = (|w_hit1) && (chk_addr1 != REG_ZERO);
   assign busy2 = (|w_hit2) && (chk_addr2 != REG_ZERO);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rf_wr   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else begin
         r_rf_wr <= w_pipe_eff || w_head_live;
         if (w_pipe_eff) begin
            r_rf_addr <= pipe_addr;
            r_rf_data <= pipe_data;
         end else if (w_head_live) begin
            r_rf_addr <= w_head.addr;
            r_rf_data <= w_head.data;
         end
      end
   end

   assign rf_wr   = r_rf_wr;
   assign rf_addr = r_rf_addr;
   assign rf_data = r_rf_data;

endmodule

`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
// ============================================================================
//  Module   : tb_wb_write_arbiter
//  Brief    : Directed vector table, reset corner cases and randomized traffic
//             against a queue-based model of the writeback arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_write_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_wr;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        busy1;
   logic        busy2;
   logic [2:0]  mdu_count;
   logic        rf_wr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_write_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .pipe_wr   (pipe_wr),
      .pipe_addr (pipe_addr),
      .pipe_data (pipe_data),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_addr  (mdu_addr),
      .mdu_data  (mdu_data),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .busy1     (busy1),
      .busy2     (busy2),
      .mdu_count (mdu_count),
      .rf_wr     (rf_wr),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Directed vector: inputs for one cycle, then outputs expected after the edge.
   typedef struct {
      logic pw; logic [4:0] pa; logic [31:0] pd;
      logic mv; logic [4:0] ma; logic [31:0] md;
      logic [4:0] c1; logic [4:0] c2;
      logic ewr; logic [4:0] ea; logic [31:0] ed;
      int   ecnt; logic erdy; logic eb1; logic eb2;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] c1, input logic [4:0] c2,
                      input logic ewr, input logic [4:0] ea, input logic [31:0] ed,
                      input int ecnt, input logic erdy, input logic eb1, input logic eb2);
      vec_t v;
      v = '{pw, pa, pd, mv, ma, md, c1, c2, ewr, ea, ed, ecnt, erdy, eb1, eb2};
      tbl.push_back(v);
   endtask

   task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      pipe_wr = pw; pipe_addr = pa; pipe_data = pd;
      mdu_valid = mv; mdu_addr = ma; mdu_data = md;
   endtask

   // Queue-level reference model
   typedef struct { logic [4:0] a; logic [31:0] d; bit k; } ent_t;
   ent_t        q[$];
   logic        m_wr;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   function automatic logic model_busy(input logic [4:0] c);
      foreach (q[i]) begin
         if (!q[i].k && q[i].a == c && c != 5'd0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_step();
      logic pe, accept, popped, nwr;
      logic [4:0] na; logic [31:0] nd;
      pe     = pipe_wr && (pipe_addr != 5'd0);
      accept = mdu_valid && (q.size() < DEPTH);
      popped = 1'b0; nwr = 1'b0; na = m_addr; nd = m_data;
      if (q.size() > 0) begin
         if (q[0].k) popped = 1'b1;
         else if (!pe) begin popped = 1'b1; nwr = 1'b1; na = q[0].a; nd = q[0].d; end
      end
      if (pe) begin nwr = 1'b1; na = pipe_addr; nd = pipe_data; end
      if (popped) void'(q.pop_front());
      if (pe) foreach (q[i]) if (q[i].a == pipe_addr) q[i].k = 1'b1;
      if (accept && mdu_addr != 5'd0 && !(pe && mdu_addr == pipe_addr))
         q.push_back('{mdu_addr, mdu_data, 1'b0});
      m_wr = nwr; m_addr = na; m_data = nd;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk_addr1 = 0; chk_addr2 = 0;
      #12 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset rf_wr", rf_wr, 0);
      check("reset rf_addr", rf_addr, 0);
      check("reset rf_data", rf_data, 0);
      check("reset mdu_ready", mdu_ready, 1);
      check("reset mdu_count", mdu_count, 0);
      check("reset busy1", busy1, 0);
      check("reset busy2", busy2, 0);

      //   pw pa  pd            mv ma  md        c1  c2   ewr ea  ed            cnt rdy b1 b2
      add(1, 5,  32'hDEADBEEF, 0, 0,  0,        0,  0,   1,  5,  32'hDEADBEEF, 0,  1,  0, 0);
      add(1, 0,  32'h12345678, 0, 0,  0,        0,  0,   0,  5,  32'hDEADBEEF, 0,  1,  0, 0);
      add(1, 3,  32'h33,       1, 7,  32'h11,   7,  8,   1,  3,  32'h33,       1,  1,  1, 0);
      add(1, 4,  32'h44,       1, 8,  32'h22,   7,  8,   1,  4,  32'h44,       2,  1,  1, 1);
      add(0, 0,  0,            0, 0,  0,        7,  8,   1,  7,  32'h11,       1,  1,  0, 1);
      add(0, 0,  0,            0, 0,  0,        7,  8,   1,  8,  32'h22,       0,  1,  0, 0);
      add(0, 0,  0,            0, 0,  0,        7,  8,   0,  8,  32'h22,       0,  1,  0, 0);
      add(1, 1,  32'h1,        1, 10, 32'hA0,   10, 13,  1,  1,  32'h1,        1,  1,  1, 0);
      add(1, 1,  32'h2,        1, 11, 32'hA1,   10, 13,  1,  1,  32'h2,        2,  1,  1, 0);
      add(1, 1,  32'h3,        1, 12, 32'hA2,   10, 13,  1,  1,  32'h3,        3,  1,  1, 0);
      add(1, 1,  32'h4,        1, 13, 32'hA3,   10, 13,  1,  1,  32'h4,        4,  0,  1, 1);
      add(1, 1,  32'h5,        1, 14, 32'hA4,   10, 13,  1,  1,  32'h5,        4,  0,  1, 1);
      add(0, 0,  0,            1, 14, 32'hA4,   10, 13,  1,  10, 32'hA0,       3,  1,  0, 1);
      add(0, 0,  0,            1, 14, 32'hA4,   10, 13,  1,  11, 32'hA1,       3,  1,  0, 1);
      add(0, 0,  0,            0, 0,  0,        10, 13,  1,  12, 32'hA2,       2,  1,  0, 1);
      add(0, 0,  0,            0, 0,  0,        10, 13,  1,  13, 32'hA3,       1,  1,  0, 0);
      add(0, 0,  0,            0, 0,  0,        10, 13,  1,  14, 32'hA4,       0,  1,  0, 0);
      add(1, 2,  32'h20,       1, 9,  32'hAA,   9,  0,   1,  2,  32'h20,       1,  1,  1, 0);
      add(1, 9,  32'hBB,       0, 0,  0,        9,  0,   1,  9,  32'hBB,       1,  1,  0, 0);
      add(0, 0,  0,            0, 0,  0,        9,  0,   0,  9,  32'hBB,       0,  1,  0, 0);
      add(1, 2,  32'h21,       1, 6,  32'h66,   6,  6,   1,  2,  32'h21,       1,  1,  1, 1);
      add(1, 6,  32'h67,       1, 6,  32'h68,   6,  6,   1,  6,  32'h67,       1,  1,  0, 0);
      add(1, 3,  32'h30,       0, 0,  0,        6,  6,   1,  3,  32'h30,       0,  1,  0, 0);
      add(0, 0,  0,            1, 0,  32'h99,   0,  0,   0,  3,  32'h30,       0,  1,  0, 0);
      add(0, 0,  0,            0, 0,  0,        0,  0,   0,  3,  32'h30,       0,  1,  0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
         chk_addr1 = tbl[i].c1; chk_addr2 = tbl[i].c2;
         @(posedge clk); #1;
         check($sformatf("vec%0d rf_wr", i), rf_wr, tbl[i].ewr);
         check($sformatf("vec%0d rf_addr", i), rf_addr, tbl[i].ea);
         check($sformatf("vec%0d rf_data", i), rf_data, tbl[i].ed);
         check($sformatf("vec%0d mdu_count", i), mdu_count, tbl[i].ecnt);
         check($sformatf("vec%0d mdu_ready", i), mdu_ready, tbl[i].erdy);
         check($sformatf("vec%0d busy1", i), busy1, tbl[i].eb1);
         check($sformatf("vec%0d busy2", i), busy2, tbl[i].eb2);
      end

      // Reset asserted mid-drain with three results still queued
      chk_addr1 = 11; chk_addr2 = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, i, 1, 5'(10 + i), 32'hC0 + i);
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check("middrain rf_wr", rf_wr, 1);
      check("middrain rf_addr", rf_addr, 10);
      check("middrain count", mdu_count, 3);
      check("middrain busy1", busy1, 1);
      #3 reset = 1'b0;
      #1;
      check("async rst rf_wr", rf_wr, 0);
      check("async rst rf_addr", rf_addr, 0);
      check("async rst rf_data", rf_data, 0);
      check("async rst count", mdu_count, 0);
      check("async rst ready", mdu_ready, 1);
      check("async rst busy1", busy1, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("post rst%0d rf_wr", i), rf_wr, 0);
         check($sformatf("post rst%0d count", i), mdu_count, 0);
      end

      // Randomized traffic from a clean state
      q.delete();
      m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      for (int n = 0; n < 600; n++) begin
         pipe_wr   = ($urandom_range(0, 9) < 4);
         pipe_addr = 5'($urandom_range(0, 7));
         pipe_data = $urandom;
         mdu_valid = ($urandom_range(0, 9) < 5);
         mdu_addr  = 5'($urandom_range(0, 7));
         mdu_data  = $urandom;
         chk_addr1 = 5'($urandom_range(0, 7));
         chk_addr2 = 5'($urandom_range(0, 7));
         #1;
         check($sformatf("rnd%0d mdu_ready", n), mdu_ready, (q.size() < DEPTH));
         check($sformatf("rnd%0d mdu_count", n), mdu_count, q.size());
         check($sformatf("rnd%0d busy1", n), busy1, model_busy(chk_addr1));
         check($sformatf("rnd%0d busy2", n), busy2, model_busy(chk_addr2));
         model_step();
         @(posedge clk); #1;
         check($sformatf("rnd%0d rf_wr", n), rf_wr, m_wr);
         check($sformatf("rnd%0d rf_addr", n), rf_addr, m_addr);
         check($sformatf("rnd%0d rf_data", n), rf_data, m_data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
